// File: rtl/ex_stage.sv
// ex_stage: openMIPS execute stage. Logic, shift, move and multiply results are combinational.
// With EX_DIV_EN defined, DIV/DIVU run on an iterative divider (33 cycles) that holds upstream through stallreq_o.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        mem_whilo_i,
  input  logic [31:0] mem_hi_i,
  input  logic [31:0] mem_lo_i,
  input  logic        wb_whilo_i,
  input  logic [31:0] wb_hi_i,
  input  logic [31:0] wb_lo_i,
  input  logic        flush_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] EXE_MOVZ_OP  = 8'b0000_1010;
  localparam logic [7:0] EXE_MOVN_OP  = 8'b0000_1011;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE  = 3'b011;

  logic [31:0] hi_fwd, lo_fwd;
  logic [31:0] logic_res, shift_res, move_res;
  logic [63:0] mul_s, mul_u;
  logic        div_stall, div_whilo;
  logic [31:0] div_hi, div_lo;

  // MEM holds the youngest pending HI/LO write, so it wins over WB.
  always_comb begin
    hi_fwd = hi_i;
    lo_fwd = lo_i;
    if (mem_whilo_i) begin
      hi_fwd = mem_hi_i;
      lo_fwd = mem_lo_i;
    end else if (wb_whilo_i) begin
      hi_fwd = wb_hi_i;
      lo_fwd = wb_lo_i;
    end
  end

  always_comb begin
    logic_res = '0;
    case (aluop_i)
      EXE_OR_OP:  logic_res = reg1_i | reg2_i;
      EXE_AND_OP: logic_res = reg1_i & reg2_i;
      EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
      default:    logic_res = '0;
    endcase
  end

  always_comb begin
    shift_res = '0;
    case (aluop_i)
      EXE_SLL_OP: shift_res = reg2_i << reg1_i[4:0];
      EXE_SRL_OP: shift_res = reg2_i >> reg1_i[4:0];
      EXE_SRA_OP: shift_res = $signed(reg2_i) >>> reg1_i[4:0];
      default:    shift_res = '0;
    endcase
  end

  always_comb begin
    move_res = '0;
    case (aluop_i)
      EXE_MFHI_OP: move_res = hi_fwd;
      EXE_MFLO_OP: move_res = lo_fwd;
      EXE_MOVN_OP,
      EXE_MOVZ_OP: move_res = reg1_i;
      default:     move_res = '0;
    endcase
  end

  assign mul_s = $signed({{32{reg1_i[31]}}, reg1_i}) * $signed({{32{reg2_i[31]}}, reg2_i});
  assign mul_u = {32'd0, reg1_i} * {32'd0, reg2_i};

`ifdef EX_DIV_EN
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE, DIV_ZERO} div_state_t;

  div_state_t  div_st;
  logic [4:0]  div_cnt;
  logic [31:0] div_rem, div_quo, div_dvs;
  logic        div_neg_q, div_neg_r, div_wr;
  logic        div_op, div_sgn;
  logic [31:0] dvd_mag, dvs_mag, fin_quo, fin_rem;
  logic [32:0] rem_sh, rem_sub;

  assign div_op  = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
  assign div_sgn = (aluop_i == EXE_DIV_OP);
  assign dvd_mag = (div_sgn && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
  assign dvs_mag = (div_sgn && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;

  // Restoring step: the dividend shifts out of div_quo while quotient bits shift in.
  assign rem_sh  = {div_rem, div_quo[31]};
  assign rem_sub = rem_sh - {1'b0, div_dvs};
  assign fin_quo = {div_quo[30:0], ~rem_sub[32]};
  assign fin_rem = rem_sub[32] ? rem_sh[31:0] : rem_sub[31:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_st    <= DIV_IDLE;
      div_cnt   <= '0;
      div_rem   <= '0;
      div_quo   <= '0;
      div_dvs   <= '0;
      div_neg_q <= 1'b0;
      div_neg_r <= 1'b0;
      div_wr    <= 1'b0;
      div_hi    <= '0;
      div_lo    <= '0;
    end else if (flush_i) begin
      div_st <= DIV_IDLE;
      div_wr <= 1'b0;
    end else begin
      case (div_st)
        DIV_IDLE: begin
          if (div_op) begin
            if (reg2_i == 32'd0) begin
              div_st <= DIV_ZERO;
              div_wr <= 1'b1;
              div_hi <= '0;
              div_lo <= '0;
            end else begin
              div_st    <= DIV_BUSY;
              div_cnt   <= '0;
              div_rem   <= '0;
              div_quo   <= dvd_mag;
              div_dvs   <= dvs_mag;
              div_neg_q <= div_sgn & (reg1_i[31] ^ reg2_i[31]);
              div_neg_r <= div_sgn & reg1_i[31];
            end
          end
        end
        DIV_BUSY: begin
          div_rem <= fin_rem;
          div_quo <= fin_quo;
          div_cnt <= div_cnt + 5'd1;
          if (div_cnt == 5'd31) begin
            // Signs applied on the last step so DONE drives straight from registers.
            div_st <= DIV_DONE;
            div_wr <= 1'b1;
            div_lo <= div_neg_q ? (~fin_quo + 32'd1) : fin_quo;
            div_hi <= div_neg_r ? (~fin_rem + 32'd1) : fin_rem;
          end
        end
        default: begin
          div_st <= DIV_IDLE;
          div_wr <= 1'b0;
        end
      endcase
    end
  end

  assign div_stall = div_op && (div_st == DIV_IDLE || div_st == DIV_BUSY);
  assign div_whilo = div_wr && !flush_i;
`else
  logic unused_div;
  assign unused_div = ^{clk, flush_i};
  assign div_stall  = 1'b0;
  assign div_whilo  = 1'b0;
  assign div_hi     = '0;
  assign div_lo     = '0;
`endif

  always_comb begin
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    whilo_o    = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    stallreq_o = 1'b0;
    if (rst) begin
      wd_o       = wd_i;
      wreg_o     = wreg_i;
      stallreq_o = div_stall;
      case (alusel_i)
        EXE_RES_LOGIC: wdata_o = logic_res;
        EXE_RES_SHIFT: wdata_o = shift_res;
        EXE_RES_MOVE:  wdata_o = move_res;
        default:       wdata_o = '0;
      endcase
      if (div_whilo) begin
        whilo_o = 1'b1;
        hi_o    = div_hi;
        lo_o    = div_lo;
      end else begin
        case (aluop_i)
          EXE_MTHI_OP: begin
            whilo_o = 1'b1;
            hi_o    = reg1_i;
            lo_o    = lo_fwd;
          end
          EXE_MTLO_OP: begin
            whilo_o = 1'b1;
            hi_o    = hi_fwd;
            lo_o    = reg1_i;
          end
          EXE_MULT_OP: begin
            whilo_o      = 1'b1;
            {hi_o, lo_o} = mul_s;
          end
          EXE_MULTU_OP: begin
            whilo_o      = 1'b1;
            {hi_o, lo_o} = mul_u;
          end
          default: begin
            whilo_o = 1'b0;
            hi_o    = '0;
            lo_o    = '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expectations queued at drive time, popped when the DUT presents a result.
module tb_ex_stage;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_MOVN  = 8'b0000_1011;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
  localparam logic [2:0] RS_NOP   = 3'b000;
  localparam logic [2:0] RS_LOGIC = 3'b001;
  localparam logic [2:0] RS_SHIFT = 3'b010;
  localparam logic [2:0] RS_MOVE  = 3'b011;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] hi_i, lo_i;
  logic        mem_whilo_i, wb_whilo_i;
  logic [31:0] mem_hi_i, mem_lo_i, wb_hi_i, wb_lo_i;
  logic        flush_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o, lo_o;
  logic        stallreq_o;

  ex_stage dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .hi_i(hi_i), .lo_i(lo_i),
    .mem_whilo_i(mem_whilo_i), .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i),
    .wb_whilo_i(wb_whilo_i), .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i),
    .flush_i(flush_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [4:0] wd_ctr = 5'd1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] wdata, input logic [4:0] wd, input logic wreg,
                          input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.wdata = wdata; e.wd = wd; e.wreg = wreg; e.whilo = whilo; e.hi = hi; e.lo = lo;
    sb_q.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, ":sb_empty"}, sb_q.size(), 1);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, ":wdata"}, wdata_o, e.wdata);
    chk({tag, ":wd"},    wd_o,    e.wd);
    chk({tag, ":wreg"},  wreg_o,  e.wreg);
    chk({tag, ":whilo"}, whilo_o, e.whilo);
    if (e.whilo) begin
      chk({tag, ":hi"}, hi_o, e.hi);
      chk({tag, ":lo"}, lo_o, e.lo);
    end
  endtask

  task automatic comb(input string tag, input logic [7:0] op, input logic [2:0] sel,
                      input logic [31:0] a, input logic [31:0] b, input logic wr,
                      input logic [31:0] ew, input logic ewhilo,
                      input logic [31:0] eh, input logic [31:0] el);
    @(negedge clk);
    wd_ctr   = wd_ctr + 5'd3;
    aluop_i  = op; alusel_i = sel; reg1_i = a; reg2_i = b;
    wd_i     = wd_ctr; wreg_i = wr;
    push_exp(ew, wd_ctr, wr, ewhilo, eh, el);
    #1;
    check_out(tag);
    chk({tag, ":stall"}, stallreq_o, 0);
  endtask

  task automatic div_run(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                         input bit mid);
    int cyc;
    int nstall;
    bit done;
    @(negedge clk);
    aluop_i = op; alusel_i = RS_NOP; reg1_i = a; reg2_i = b;
    wd_i = 5'd9; wreg_i = 1'b0; flush_i = 1'b0;
`ifdef EX_DIV_EN
    push_exp(32'd0, 5'd9, 1'b0, 1'b1, er, eq);
    #1;
    chk({tag, ":stall0"}, stallreq_o, 1);
    nstall = stallreq_o ? 1 : 0;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 60) begin
      @(negedge clk); #1;
      cyc++;
      if (mid && cyc == 5) begin
        reg1_i = ~a;
        reg2_i = b + 32'd3;
      end
      if (whilo_o) done = 1'b1;
      else if (stallreq_o) nstall++;
    end
    chk({tag, ":latency"}, cyc, (b == 32'd0) ? 1 : 33);
    chk({tag, ":nstall"}, nstall, (b == 32'd0) ? 1 : 33);
    chk({tag, ":stall_end"}, stallreq_o, 0);
    check_out(tag);
`else
    push_exp(32'd0, 5'd9, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check_out(tag);
    chk({tag, ":stall"}, stallreq_o, 0);
    if (mid) chk({tag, ":q_unused"}, eq ^ eq, 0);
`endif
  endtask

  function automatic logic [31:0] logic_model(input logic [7:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
    case (op)
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0]  ops[4];
    logic [31:0] ra, rb;
    logic [7:0]  op;
    bit          seen;

    ops[0] = OP_OR; ops[1] = OP_AND; ops[2] = OP_XOR; ops[3] = OP_NOR;
    rst = 1'b0;
    aluop_i = OP_MULT; alusel_i = RS_LOGIC; reg1_i = 32'hF0; reg2_i = 32'h0F;
    wd_i = 5'd7; wreg_i = 1'b1; hi_i = 32'h9ABC; lo_i = 32'hAAAA;
    mem_whilo_i = 1'b0; mem_hi_i = 32'h1234; mem_lo_i = 32'h4321;
    wb_whilo_i = 1'b0; wb_hi_i = 32'h5678; wb_lo_i = 32'h8765; flush_i = 1'b0;

    #2;
    push_exp(32'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_out("reset");
    chk("reset:hi", hi_o, 0);
    chk("reset:lo", lo_o, 0);
    chk("reset:stall", stallreq_o, 0);
    @(negedge clk);
    rst = 1'b1;

    comb("ori",  OP_OR,  RS_LOGIC, 32'hF0, 32'h0F, 1'b1, 32'hFF, 1'b0, 0, 0);
    comb("and",  OP_AND, RS_LOGIC, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 32'h0F000F00, 1'b0, 0, 0);
    comb("nor",  OP_NOR, RS_LOGIC, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b0, 0, 0);
    comb("sra",  OP_SRA, RS_SHIFT, 32'd4, 32'h80000000, 1'b1, 32'hF8000000, 1'b0, 0, 0);
    comb("srl",  OP_SRL, RS_SHIFT, 32'd8, 32'h80000000, 1'b1, 32'h00800000, 1'b0, 0, 0);
    comb("sll",  OP_SLL, RS_SHIFT, 32'h24, 32'h1, 1'b1, 32'h10, 1'b0, 0, 0);
    comb("movn", OP_MOVN, RS_MOVE, 32'hCAFEF00D, 32'h1, 1'b1, 32'hCAFEF00D, 1'b0, 0, 0);
    comb("badsel", OP_OR, 3'b111, 32'hF0, 32'h0F, 1'b1, 32'h0, 1'b0, 0, 0);

    mem_whilo_i = 1'b1; wb_whilo_i = 1'b1;
    comb("mfhi_mem", OP_MFHI, RS_MOVE, 0, 0, 1'b1, 32'h1234, 1'b0, 0, 0);
    mem_whilo_i = 1'b0;
    comb("mflo_wb", OP_MFLO, RS_MOVE, 0, 0, 1'b1, 32'h8765, 1'b0, 0, 0);
    comb("mthi_wb", OP_MTHI, RS_NOP, 32'h11112222, 0, 1'b0, 0, 1'b1, 32'h11112222, 32'h8765);
    wb_whilo_i = 1'b0;
    comb("mfhi_arch", OP_MFHI, RS_MOVE, 0, 0, 1'b1, 32'h9ABC, 1'b0, 0, 0);
    comb("mtlo_arch", OP_MTLO, RS_NOP, 32'h33334444, 0, 1'b0, 0, 1'b1, 32'h9ABC, 32'h33334444);

    comb("mult",  OP_MULT,  RS_NOP, 32'hFFFFFFFD, 32'd5, 1'b0, 0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1);
    comb("multu", OP_MULTU, RS_NOP, 32'hFFFFFFFF, 32'd2, 1'b0, 0, 1'b1, 32'h1, 32'hFFFFFFFE);
    comb("mult_min", OP_MULT, RS_NOP, 32'h80000000, 32'h80000000, 1'b0, 0, 1'b1, 32'h40000000, 32'h0);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom; rb = $urandom;
      op = ops[$urandom_range(0, 3)];
      comb("rnd_logic", op, RS_LOGIC, ra, rb, 1'b1, logic_model(op, ra, rb), 1'b0, 0, 0);
    end

    div_run("div_m7_2",   OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    div_run("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);
    div_run("div_ovf",    OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
    div_run("div_7_m2",   OP_DIV,  32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0);
    div_run("divu_max",   OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);
    div_run("divu_5_9",   OP_DIVU, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0);
    div_run("div_zero",   OP_DIV,  32'd42, 32'd0, 32'd0, 32'd0, 1'b0);
    comb("after_div", OP_OR, RS_LOGIC, 32'h1, 32'h2, 1'b1, 32'h3, 1'b0, 0, 0);

`ifdef EX_DIV_EN
    @(negedge clk);
    aluop_i = OP_DIVU; alusel_i = RS_NOP; reg1_i = 32'd100; reg2_i = 32'd7;
    wd_i = 5'd9; wreg_i = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk); #1;
      seen |= whilo_o;
    end
    flush_i = 1'b1;
    @(negedge clk); #1;
    seen |= whilo_o;
    flush_i = 1'b0;
    reg2_i = 32'd0;
    chk("flush:no_write", seen, 0);
    chk("flush:stall11", stallreq_o, 1);
    push_exp(32'd0, 5'd9, 1'b0, 1'b1, 32'd0, 32'd0);
    @(negedge clk); #1;
    check_out("flush:idle_then_zero");

    @(negedge clk);
    aluop_i = OP_DIVU; reg1_i = 32'd100; reg2_i = 32'd7; wd_i = 5'd5; wreg_i = 1'b1;
    seen = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); #1;
      seen |= whilo_o;
    end
    rst = 1'b0;
    #1;
    push_exp(32'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_out("rst_mid");
    chk("rst_mid:hi", hi_o, 0);
    chk("rst_mid:lo", lo_o, 0);
    chk("rst_mid:stall", stallreq_o, 0);
    @(negedge clk);
    aluop_i = OP_NOP; rst = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      seen |= whilo_o;
    end
    chk("rst_mid:no_write", seen, 0);
`endif

    div_run("div_post", OP_DIV, 32'hFFFFFF9C, 32'd10, 32'hFFFFFFF6, 32'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
